// File: rtl/instr_sequencer_pkg.sv
// Shared encodings for the instruction sequencer: opcode/op fields, datapath
// select codes, memory commands, FSM states and the registered control bundle.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    OPC_LDR  = 3'b011,
    OPC_STR  = 3'b100,
    OPC_ALU  = 3'b101,
    OPC_MOV  = 3'b110,
    OPC_HALT = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_CMP = 2'b01,
    ALU_AND = 2'b10,
    ALU_MVN = 2'b11
  } alu_op_t;

  // op field encodings under the MOV opcode
  localparam logic [1:0] MOV_SH  = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;
  // LDR/STR only accept this op field
  localparam logic [1:0] LDST_OP = 2'b00;

  typedef enum logic [1:0] {
    REG_RM = 2'b00,
    REG_RD = 2'b01,
    REG_RN = 2'b10
  } reg_sel_t;

  typedef enum logic [1:0] {
    WB_C     = 2'b00,
    WB_IMM   = 2'b10,
    WB_MDATA = 2'b11
  } wb_sel_t;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_cmd_t;

  typedef enum logic [4:0] {
    S_IDLE,
    S_GET_A,
    S_GET_B,
    S_EXEC,      // plain ALU execute
    S_EXEC_MV,   // execute with A forced to 0 (MOV shift, MVN)
    S_EXEC_IMM,  // address calc: Rn + sximm5
    S_WB,
    S_WB_IMM,
    S_WB_ST,
    S_ADDR,
    S_MEM_RD,
    S_LD_WB,
    S_GET_D,
    S_EXEC_D,    // pass store data through C
    S_MEM_WR,
    S_HALT,
    S_ERR
  } state_t;

  typedef struct packed {
    logic     waiting;
    logic     err;
    logic     halted;
    reg_sel_t reg_sel;
    wb_sel_t  wb_sel;
    logic     w_en;
    logic     en_a;
    logic     en_b;
    logic     en_c;
    logic     en_status;
    logic     sel_a;
    logic     sel_b;
    logic     load_addr;
    mem_cmd_t mem_cmd;
  } ctrl_t;

  // First state after an accepted start; illegal encodings go straight to ERR.
  function automatic state_t first_state(input logic [2:0] opcode,
                                         input logic [1:0] op,
                                         input logic       en_ldst);
    state_t s;
    s = S_ERR;
    case (opcode)
      OPC_MOV: begin
        if (op == MOV_IMM)     s = S_WB_IMM;
        else if (op == MOV_SH) s = S_GET_B;
        else                   s = S_ERR;
      end
      OPC_ALU:  s = (op == ALU_MVN) ? S_GET_B : S_GET_A;
      OPC_LDR,
      OPC_STR:  s = (en_ldst && (op == LDST_OP)) ? S_GET_A : S_ERR;
      OPC_HALT: s = S_HALT;
      default:  s = S_ERR;
    endcase
    return s;
  endfunction

  // Control outputs asserted while sitting in a given state.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_IDLE:     c.waiting = 1'b1;
      S_GET_A:    begin c.reg_sel = REG_RN; c.en_a = 1'b1; end
      S_GET_B:    begin c.reg_sel = REG_RM; c.en_b = 1'b1; end
      S_EXEC:     c.en_c = 1'b1;
      S_EXEC_MV:  begin c.sel_a = 1'b1; c.en_c = 1'b1; end
      S_EXEC_IMM: begin c.sel_b = 1'b1; c.en_c = 1'b1; end
      S_WB:       begin c.reg_sel = REG_RD; c.wb_sel = WB_C; c.w_en = 1'b1; end
      S_WB_IMM:   begin c.reg_sel = REG_RN; c.wb_sel = WB_IMM; c.w_en = 1'b1; end
      S_WB_ST:    c.en_status = 1'b1;
      S_ADDR:     c.load_addr = 1'b1;
      S_MEM_RD:   c.mem_cmd = MEM_READ;
      S_LD_WB:    begin c.reg_sel = REG_RD; c.wb_sel = WB_MDATA; c.w_en = 1'b1; end
      S_GET_D:    begin c.reg_sel = REG_RD; c.en_b = 1'b1; end
      S_EXEC_D:   begin c.sel_a = 1'b1; c.en_c = 1'b1; end
      S_MEM_WR:   c.mem_cmd = MEM_WRITE;
      S_HALT:     c.halted = 1'b1;
      S_ERR:      c.err = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instr_sequencer_mem_timeout_ctr.sv
// Memory-wait cycle counter. clear has priority over inc; expired is
// registered and high in the cycle where the count equals MAX_COUNT-1.
//   clk, rst_n : clock, async active-low reset
//   clear      : return count to 0
//   inc        : advance count by one
//   expired    : count == MAX_COUNT-1
module instr_sequencer_mem_timeout_ctr #(
  parameter int unsigned MAX_COUNT = 16,
  parameter int unsigned W         = $clog2(MAX_COUNT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)    cnt_d = '0;
    else if (inc) cnt_d = cnt_q + W'(1);
  end

  // expired tracks the next count so it lines up with cnt_q without a comparator on the output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      expired <= 1'(MAX_COUNT == 1);
    end else begin
      cnt_q   <= cnt_d;
      expired <= (cnt_d == W'(MAX_COUNT - 1));
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Datapath controller for the 16-bit RISC: latches opcode/op on start and
// steps through register-file, A/B/C, status and memory-interface enables.
// LDR/STR wait on mem_ack with a timeout; HALT and illegal opcodes are
// sticky until reset.
//   clk, rst_n        : clock, async active-low reset
//   start, opcode, op : instruction issue (sampled in IDLE only)
//   mem_ack           : memory read/write complete
//   waiting/done/err/halted : status
//   reg_sel, wb_sel, w_en, en_A/B/C, en_status, sel_A, sel_B,
//   load_addr, mem_cmd : datapath controls (all registered)
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          EN_LDST     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic       mem_ack,
  output logic       waiting,
  output logic       done,
  output logic       err,
  output logic       halted,
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A,
  output logic       sel_B,
  output logic       load_addr,
  output logic [1:0] mem_cmd
);

  localparam int unsigned CTR_W = $clog2(MEM_TIMEOUT + 1);

  state_t     state_q, state_d;
  logic [2:0] opcode_q;
  logic [1:0] op_q;
  ctrl_t      ctrl_q, ctrl_d;
  logic       done_q, done_d;
  logic       in_mem;
  logic       ctr_inc;
  logic       ctr_clear;
  logic       ctr_expired;

  instr_sequencer_mem_timeout_ctr #(
    .MAX_COUNT (MEM_TIMEOUT),
    .W         (CTR_W)
  ) u_mem_timeout_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (ctr_clear),
    .inc     (ctr_inc),
    .expired (ctr_expired)
  );

  // Next-state, counter control, done and next registered controls
  always_comb begin
    state_d   = state_q;
    in_mem    = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    ctr_inc   = in_mem && !mem_ack && !ctr_expired;
    ctr_clear = !ctr_inc;

    case (state_q)
      S_IDLE:     if (start) state_d = first_state(opcode, op, EN_LDST);
      S_GET_A:    state_d = (opcode_q == OPC_ALU) ? S_GET_B : S_EXEC_IMM;
      S_GET_B: begin
        if ((opcode_q == OPC_MOV) || (op_q == ALU_MVN)) state_d = S_EXEC_MV;
        else                                             state_d = S_EXEC;
      end
      S_EXEC:     state_d = (op_q == ALU_CMP) ? S_WB_ST : S_WB;
      S_EXEC_MV:  state_d = S_WB;
      S_EXEC_IMM: state_d = S_ADDR;
      S_ADDR:     state_d = (opcode_q == OPC_LDR) ? S_MEM_RD : S_GET_D;
      S_GET_D:    state_d = S_EXEC_D;
      S_EXEC_D:   state_d = S_MEM_WR;
      // ack in the expiry cycle takes priority over the timeout
      S_MEM_RD: begin
        if (mem_ack)          state_d = S_LD_WB;
        else if (ctr_expired) state_d = S_ERR;
      end
      S_MEM_WR: begin
        if (mem_ack)          state_d = S_IDLE;
        else if (ctr_expired) state_d = S_ERR;
      end
      S_WB, S_WB_IMM, S_WB_ST, S_LD_WB: state_d = S_IDLE;
      S_HALT:     state_d = S_HALT;
      S_ERR:      state_d = S_ERR;
      default:    state_d = S_ERR;
    endcase

    // HALT/ERR never return to IDLE, so any IDLE entry is a completed sequence
    done_d = (state_d == S_IDLE) && (state_q != S_IDLE);
    ctrl_d = state_ctrl(state_d);
  end

  // State, instruction latch, done and registered controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      op_q     <= '0;
      ctrl_q   <= state_ctrl(S_IDLE);
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      done_q  <= done_d;
      if ((state_q == S_IDLE) && start) begin
        opcode_q <= opcode;
        op_q     <= op;
      end
    end
  end

  assign waiting   = ctrl_q.waiting;
  assign done      = done_q;
  assign err       = ctrl_q.err;
  assign halted    = ctrl_q.halted;
  assign reg_sel   = ctrl_q.reg_sel;
  assign wb_sel    = ctrl_q.wb_sel;
  assign w_en      = ctrl_q.w_en;
  assign en_A      = ctrl_q.en_a;
  assign en_B      = ctrl_q.en_b;
  assign en_C      = ctrl_q.en_c;
  assign en_status = ctrl_q.en_status;
  assign sel_A     = ctrl_q.sel_a;
  assign sel_B     = ctrl_q.sel_b;
  assign load_addr = ctrl_q.load_addr;
  assign mem_cmd   = ctrl_q.mem_cmd;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle expected output vectors
// for each instruction class, back-to-back issue, memory wait/timeout,
// sticky HALT/ERR and asynchronous reset.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       mem_ack;

  logic       waiting, done, err, halted, w_en, en_A, en_B, en_C, en_status;
  logic       sel_A, sel_B, load_addr;
  logic [1:0] reg_sel, wb_sel, mem_cmd;

  logic       waiting2, done2, err2, halted2, w_en2, en_A2, en_B2, en_C2, en_status2;
  logic       sel_A2, sel_B2, load_addr2;
  logic [1:0] reg_sel2, wb_sel2, mem_cmd2;

  int tests_run = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.MEM_TIMEOUT(4), .EN_LDST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .op(op), .mem_ack(mem_ack),
    .waiting(waiting), .done(done), .err(err), .halted(halted),
    .reg_sel(reg_sel), .wb_sel(wb_sel), .w_en(w_en), .en_A(en_A), .en_B(en_B), .en_C(en_C),
    .en_status(en_status), .sel_A(sel_A), .sel_B(sel_B), .load_addr(load_addr), .mem_cmd(mem_cmd)
  );

  // Second instance with LDR/STR disabled
  instr_sequencer #(.MEM_TIMEOUT(4), .EN_LDST(1'b0)) dut_nols (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .op(op), .mem_ack(mem_ack),
    .waiting(waiting2), .done(done2), .err(err2), .halted(halted2),
    .reg_sel(reg_sel2), .wb_sel(wb_sel2), .w_en(w_en2), .en_A(en_A2), .en_B(en_B2), .en_C(en_C2),
    .en_status(en_status2), .sel_A(sel_A2), .sel_B(sel_B2), .load_addr(load_addr2), .mem_cmd(mem_cmd2)
  );

  // {w_en,en_A,en_B,en_C,en_status,sel_A,sel_B,load_addr, mem_cmd, reg_sel, wb_sel, err,halted,done,waiting}
  logic [17:0] outs;
  assign outs = {w_en, en_A, en_B, en_C, en_status, sel_A, sel_B, load_addr,
                 mem_cmd, reg_sel, wb_sel, err, halted, done, waiting};

  function automatic logic [17:0] v(input logic [7:0] c, input logic [1:0] m,
                                    input logic [1:0] rs, input logic [1:0] wb,
                                    input logic [3:0] f);
    return {c, m, rs, wb, f};
  endfunction

  localparam logic [17:0] IDL = v(8'b00000000, 2'b00, 2'b00, 2'b00, 4'b0001);
  localparam logic [17:0] DON = v(8'b00000000, 2'b00, 2'b00, 2'b00, 4'b0011);
  localparam logic [17:0] GA  = v(8'b01000000, 2'b00, 2'b10, 2'b00, 4'b0000);
  localparam logic [17:0] GB  = v(8'b00100000, 2'b00, 2'b00, 2'b00, 4'b0000);
  localparam logic [17:0] EX  = v(8'b00010000, 2'b00, 2'b00, 2'b00, 4'b0000);
  localparam logic [17:0] EXM = v(8'b00010100, 2'b00, 2'b00, 2'b00, 4'b0000);
  localparam logic [17:0] EXI = v(8'b00010010, 2'b00, 2'b00, 2'b00, 4'b0000);
  localparam logic [17:0] WB  = v(8'b10000000, 2'b00, 2'b01, 2'b00, 4'b0000);
  localparam logic [17:0] WBI = v(8'b10000000, 2'b00, 2'b10, 2'b10, 4'b0000);
  localparam logic [17:0] WBS = v(8'b00001000, 2'b00, 2'b00, 2'b00, 4'b0000);
  localparam logic [17:0] ADR = v(8'b00000001, 2'b00, 2'b00, 2'b00, 4'b0000);
  localparam logic [17:0] MRD = v(8'b00000000, 2'b01, 2'b00, 2'b00, 4'b0000);
  localparam logic [17:0] LDW = v(8'b10000000, 2'b00, 2'b01, 2'b11, 4'b0000);
  localparam logic [17:0] GD  = v(8'b00100000, 2'b00, 2'b01, 2'b00, 4'b0000);
  localparam logic [17:0] MWR = v(8'b00000000, 2'b10, 2'b00, 2'b00, 4'b0000);
  localparam logic [17:0] ERS = v(8'b00000000, 2'b00, 2'b00, 2'b00, 4'b1000);
  localparam logic [17:0] HLT = v(8'b00000000, 2'b00, 2'b00, 2'b00, 4'b0100);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; opcode = '0; op = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic [2:0] opc, input logic [1:0] o);
    start = 1'b1; opcode = opc; op = o;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (outs !== IDL) begin
      failures++; $display("FAIL reset_state: got %b want %b", outs, IDL);
    end
    tick();
    tests_run++;
    if (outs !== IDL || waiting2 !== 1'b1) begin
      failures++; $display("FAIL reset_idle_hold: got %b/%b want %b/1", outs, waiting2, IDL);
    end
  endtask

  // ADD then CMP; mem_ack held high throughout to show it is ignored
  task automatic test_alu();
    logic [17:0] e[$];
    issue(3'b101, 2'b00); mem_ack = 1'b1;
    e = '{GA, GB, EX, WB, DON, IDL};
    for (int i = 0; i < e.size(); i++) begin
      tick(); start = 1'b0;
      tests_run++;
      if (outs !== e[i]) begin
        failures++; $display("FAIL add[%0d]: got %b want %b", i, outs, e[i]);
      end
    end
    issue(3'b101, 2'b01);
    e = '{GA, GB, EX, WBS, DON, IDL};
    for (int i = 0; i < e.size(); i++) begin
      tick(); start = 1'b0;
      tests_run++;
      if (outs !== e[i]) begin
        failures++; $display("FAIL cmp[%0d]: got %b want %b", i, outs, e[i]);
      end
    end
    mem_ack = 1'b0;
  endtask

  // MOV imm, then MVN issued in the done cycle
  task automatic test_back_to_back();
    logic [17:0] e[$];
    int done_cnt;
    done_cnt = 0;
    issue(3'b110, 2'b10);
    e = '{WBI, DON, GB, EXM, WB, DON, IDL};
    for (int i = 0; i < e.size(); i++) begin
      tick(); start = 1'b0;
      if (done === 1'b1) done_cnt++;
      tests_run++;
      if (outs !== e[i]) begin
        failures++; $display("FAIL b2b[%0d]: got %b want %b", i, outs, e[i]);
      end
      if (i == 1) issue(3'b101, 2'b11);
    end
    tests_run++;
    if (done_cnt !== 2) begin
      failures++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt);
    end
  endtask

  // LDR with ack in the 4th MEM_RD cycle (also the timeout cycle: ack wins)
  task automatic test_ldr();
    logic [17:0] e[$];
    issue(3'b011, 2'b00);
    e = '{GA, EXI, ADR, MRD, MRD, MRD, MRD, LDW, DON};
    for (int i = 0; i < e.size(); i++) begin
      tick(); start = 1'b0; mem_ack = 1'b0;
      tests_run++;
      if (outs !== e[i]) begin
        failures++; $display("FAIL ldr[%0d]: got %b want %b", i, outs, e[i]);
      end
      if (i == 0) begin
        tests_run++;
        if (err2 !== 1'b1 || waiting2 !== 1'b0) begin
          failures++; $display("FAIL ldr_disabled_err: got err=%b waiting=%b want err=1 waiting=0", err2, waiting2);
        end
      end
      if (i == 6) mem_ack = 1'b1;
    end
  endtask

  // STR with no ack: 4 MEM_WR cycles then sticky ERR; start and ack ignored
  task automatic test_str_timeout();
    logic [17:0] e[$];
    do_reset();
    issue(3'b100, 2'b00);
    e = '{GA, EXI, ADR, GD, EXM, MWR, MWR, MWR, MWR, ERS, ERS, ERS};
    for (int i = 0; i < e.size(); i++) begin
      tick(); start = 1'b0; mem_ack = 1'b0;
      tests_run++;
      if (outs !== e[i]) begin
        failures++; $display("FAIL str_timeout[%0d]: got %b want %b", i, outs, e[i]);
      end
      if (i == 9) issue(3'b101, 2'b00);
      if (i == 10) mem_ack = 1'b1;
    end
    do_reset();
  endtask

  // STR with ack in the last allowed cycle
  task automatic test_str_ack();
    logic [17:0] e[$];
    issue(3'b100, 2'b00);
    e = '{GA, EXI, ADR, GD, EXM, MWR, MWR, MWR, MWR, DON, IDL};
    for (int i = 0; i < e.size(); i++) begin
      tick(); start = 1'b0; mem_ack = 1'b0;
      tests_run++;
      if (outs !== e[i]) begin
        failures++; $display("FAIL str_ack[%0d]: got %b want %b", i, outs, e[i]);
      end
      if (i == 8) mem_ack = 1'b1;
    end
  endtask

  task automatic test_illegal_halt();
    logic [17:0] e[$];
    logic [2:0]  opcs[3];
    logic [1:0]  ops[3];
    opcs = '{3'b000, 3'b110, 3'b111};
    ops  = '{2'b00, 2'b01, 2'b01};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      issue(opcs[k], ops[k]);
      if (k == 2) e = '{HLT, HLT, HLT};
      else        e = '{ERS, ERS, ERS};
      for (int i = 0; i < e.size(); i++) begin
        tick(); start = 1'b0;
        tests_run++;
        if (outs !== e[i]) begin
          failures++; $display("FAIL sticky_%0d[%0d]: got %b want %b", k, i, outs, e[i]);
        end
        if (i == 0) issue(3'b101, 2'b00);
      end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if (outs !== IDL) begin
        failures++; $display("FAIL sticky_%0d_async_reset: got %b want %b", k, outs, IDL);
      end
    end
    do_reset();
  endtask

  // Reset while ADD is in GET_B
  task automatic test_reset_mid();
    issue(3'b101, 2'b00);
    tick(); start = 1'b0;
    tick();
    tests_run++;
    if (outs !== GB) begin
      failures++; $display("FAIL mid_reset_pre: got %b want %b", outs, GB);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (outs !== IDL) begin
      failures++; $display("FAIL mid_reset_async: got %b want %b", outs, IDL);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (outs !== IDL) begin
      failures++; $display("FAIL mid_reset_after: got %b want %b", outs, IDL);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; opcode = '0; op = '0; mem_ack = 1'b0;
    test_reset();
    test_alu();
    test_back_to_back();
    test_ldr();
    test_str_timeout();
    test_str_ack();
    test_illegal_halt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
